ext_fifo_chan_demux: RTL and testbench
======================================

Name: ext_fifo_chan_demux

Overview:
Packet-atomic 1:2 steering stage that sits directly upstream of the external SRAM FIFO's two write channels, on the int_clk side.
- Accepts one 36-bit framed stream (bit32 SOF, bit33 EOF, bits35:34 occupancy).
- Selects channel 0 or 1 from a header bit in the first word of each packet.
- Drives a single shared data bus plus per-channel src_rdy/dst_rdy pairs into the FIFO's two input ports.
- Has a one-word registered output stage and saturating status counters.

Parameters:
WIDTH, 36, word width including the 4 flag bits.
CHAN_BIT, 16, index in data_i[31:0] of the SOF word that selects the channel (0 → ch0, 1 → ch1).
CNT_W, 16, width of each status counter.

Ports:
clk  in  1  int_clk domain clock
rst  in  1  reset
data_i  in  WIDTH  input word
src_rdy_i  in  1  input word valid
dst_rdy_o  out  1  input word accepted when high with src_rdy_i
data_o  out  WIDTH  registered word, shared by both channels
src0_rdy_o  out  1  data_o valid for channel 0
dst0_rdy_i  in  1  channel 0 can take the word (FIFO not full)
src1_rdy_o  out  1  data_o valid for channel 1
dst1_rdy_i  in  1  channel 1 can take the word
pkt0_cnt  out  CNT_W  packets (EOF words) delivered on ch0
pkt1_cnt  out  CNT_W  packets delivered on ch1
drop_cnt  out  CNT_W  words dropped outside a packet
err_cnt  out  CNT_W  SOF seen while inside a packet
busy  out  1  state != IDLE or output register valid

Behaviour:
- Clocking and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - state = IDLE, out_valid = 0, dest = 0.
  - data_o = 0, all counters = 0.
  - src0_rdy_o = src1_rdy_o = 0, dst_rdy_o = 1 on the first cycle after reset.
- Output register:
  - src0_rdy_o = out_valid & ~dest; src1_rdy_o = out_valid & dest.
  - out_taken = out_valid & (dest ? dst1_rdy_i : dst0_rdy_i).
  - The register only updates on accept, so data_o is held stable while not taken.
- Input handshake:
  - dst_rdy_o = ~out_valid | out_taken. This is combinational from dst*_rdy_i, which allows full throughput of 1 word/clk.
  - accept = src_rdy_i & dst_rdy_o.
  - Latency is 1 clk from accept to src*_rdy_o.
- On accept with a load: data_o <= data_i, dest <= selected channel, out_valid <= 1.
- On out_taken with no load: out_valid <= 0.
- FSM states IDLE, PKT0, PKT1, updated only on accept.
  - IDLE, SOF=1: load with dest = data_i[CHAN_BIT]. If EOF=1 stay in IDLE, else go to PKT0/PKT1 per the channel bit.
  - IDLE, SOF=0: word is consumed but not loaded; drop_cnt++. out_valid follows out_taken only.
  - PKTn, SOF=0: load with dest = n. If EOF=1 go to IDLE, else stay in PKTn.
  - PKTn, SOF=1: err_cnt++. The word is treated as a new packet start: dest and next state are re-evaluated exactly as in IDLE. No EOF is inserted into the prior packet.
- A channel change never happens while a word is pending. The new dest is only written when the register is loaded, which requires the previous word taken or the register empty.
- A downstream channel stalled indefinitely stalls the input. There is no bypass to the other channel (head-of-line blocking is accepted).
- Counters:
  - pkt0_cnt/pkt1_cnt increment on out_taken of a word with EOF=1 for ch0/ch1.
  - All counters saturate at all-ones; there is no wrap.
- Simultaneous load and take in one cycle: out_valid stays 1 and the new word replaces the old one.
- rst mid-packet: state returns to IDLE and the pending word is discarded. The remainder of the interrupted packet is dropped as non-SOF words (drop_cnt counts them).

Decomposition:
- Shared package holds:
  - flag bit indices: SOF = 32, EOF = 33, OCC = 35:34;
  - FSM state encoding: IDLE = 2'd0, PKT0 = 2'd1, PKT1 = 2'd2.
- One sub-module is natural: sat_counter (parameter W; inputs clk, rst, inc; output count), instantiated four times.

Test Plan:
- Single-word packet: SOF+EOF with bit16 = 1, both dst ready → src1_rdy_o one clk later, data_o equal to the input, pkt1_cnt = 1, src0_rdy_o never high.
- Back-to-back packets, no stall: 3-word packet to ch0 then 2-word packet to ch1 → 5 consecutive valid cycles, dest switches at the word boundary, dst_rdy_o stays high throughout, pkt0_cnt = 1, pkt1_cnt = 1.
- Backpressure: dst0_rdy_i low for 4 clks mid-packet → data_o held constant, dst_rdy_o low, no word lost or duplicated. Ch1 traffic is blocked until ch0's packet finishes.
- Stray words: two non-SOF words while in IDLE → no src*_rdy_o pulse, drop_cnt = 2.
- Truncated packet: SOF(ch0), data, then SOF(ch1)+EOF → err_cnt = 1, the third word is steered to ch1, state = IDLE, pkt1_cnt = 1, pkt0_cnt = 0.
- Reset mid-packet: rst asserted for 1 clk after the second word of a 4-word packet → outputs return to reset values, the remaining 2 words give drop_cnt = 2, and the next SOF is steered normally.

Source files
------------

// File: rtl/ext_fifo_chan_demux_pkg.sv
// Shared constants for the external SRAM FIFO channel demux: framing flag
// positions, FSM encoding and status counter slots.
package ext_fifo_chan_demux_pkg;

    localparam int SOF_BIT = 32;
    localparam int EOF_BIT = 33;
    localparam int OCC_HI  = 35;
    localparam int OCC_LO  = 34;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PKT0 = 2'd1;
    localparam logic [1:0] ST_PKT1 = 2'd2;

    localparam int CNT_PKT0 = 0;
    localparam int CNT_PKT1 = 1;
    localparam int CNT_DROP = 2;
    localparam int CNT_ERR  = 3;
    localparam int NUM_CNT  = 4;

endpackage

// File: rtl/ext_fifo_chan_demux_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (inc && (count_reg != '1)) begin
            count_reg <= count_reg + W'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/ext_fifo_chan_demux.sv
// Packet-atomic 1:2 steering stage feeding the two write ports of the
// external SRAM FIFO through one shared, registered data bus.
module ext_fifo_chan_demux
    import ext_fifo_chan_demux_pkg::*;
#(
    parameter int WIDTH    = 36,
    parameter int CHAN_BIT = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_i,
    input  logic             src_rdy_i,
    output logic             dst_rdy_o,
    output logic [WIDTH-1:0] data_o,
    output logic             src0_rdy_o,
    input  logic             dst0_rdy_i,
    output logic             src1_rdy_o,
    input  logic             dst1_rdy_i,
    output logic [CNT_W-1:0] pkt0_cnt,
    output logic [CNT_W-1:0] pkt1_cnt,
    output logic [CNT_W-1:0] drop_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             busy
);

    logic [1:0]       state_reg, state_next;
    logic             out_valid_reg, out_valid_next;
    logic             dest_reg, dest_next;
    logic [WIDTH-1:0] data_reg, data_next;

    logic             out_taken;
    logic             accept;
    logic             in_sof, in_eof, in_chan, in_idle;
    logic [NUM_CNT-1:0] cnt_inc;
    logic [CNT_W-1:0]   cnt_val [NUM_CNT];

    assign in_sof  = data_i[SOF_BIT];
    assign in_eof  = data_i[EOF_BIT];
    assign in_chan = data_i[CHAN_BIT];
    // Any unused encoding is treated as IDLE so a corrupted state self-heals.
    assign in_idle = (state_reg != ST_PKT0) && (state_reg != ST_PKT1);

    assign out_taken = out_valid_reg & (dest_reg ? dst1_rdy_i : dst0_rdy_i);
    assign dst_rdy_o = ~out_valid_reg | out_taken;
    assign accept    = src_rdy_i & dst_rdy_o;

    always_comb begin
        state_next     = state_reg;
        out_valid_next = out_valid_reg & ~out_taken;
        dest_next      = dest_reg;
        data_next      = data_reg;
        if (accept) begin
            if (in_sof) begin
                // A SOF always restarts steering, even inside an unfinished packet.
                out_valid_next = 1'b1;
                dest_next      = in_chan;
                data_next      = data_i;
                state_next     = in_eof ? ST_IDLE : (in_chan ? ST_PKT1 : ST_PKT0);
            end else if (!in_idle) begin
                out_valid_next = 1'b1;
                dest_next      = (state_reg == ST_PKT1);
                data_next      = data_i;
                state_next     = in_eof ? ST_IDLE : state_reg;
            end else begin
                state_next     = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            out_valid_reg <= 1'b0;
            dest_reg      <= 1'b0;
            data_reg      <= '0;
        end else begin
            state_reg     <= state_next;
            out_valid_reg <= out_valid_next;
            dest_reg      <= dest_next;
            data_reg      <= data_next;
        end
    end

    assign cnt_inc[CNT_PKT0] = out_taken & ~dest_reg & data_reg[EOF_BIT];
    assign cnt_inc[CNT_PKT1] = out_taken &  dest_reg & data_reg[EOF_BIT];
    assign cnt_inc[CNT_DROP] = accept & ~in_sof & in_idle;
    assign cnt_inc[CNT_ERR]  = accept &  in_sof & ~in_idle;

    generate
        for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
            sat_counter #(.W(CNT_W)) u_cnt (
                .clk   (clk),
                .rst   (rst),
                .inc   (cnt_inc[gi]),
                .count (cnt_val[gi])
            );
        end
    endgenerate

    assign pkt0_cnt   = cnt_val[CNT_PKT0];
    assign pkt1_cnt   = cnt_val[CNT_PKT1];
    assign drop_cnt   = cnt_val[CNT_DROP];
    assign err_cnt    = cnt_val[CNT_ERR];

    assign data_o     = data_reg;
    assign src0_rdy_o = out_valid_reg & ~dest_reg;
    assign src1_rdy_o = out_valid_reg &  dest_reg;
    assign busy       = ~in_idle | out_valid_reg;

endmodule

// File: tb/tb_ext_fifo_chan_demux.sv
// Directed and randomized bench for ext_fifo_chan_demux against a
// packet-level reference model of the delivered word stream.
module tb_ext_fifo_chan_demux;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [35:0] data_i = '0;
    logic        src_rdy_i = 1'b0;
    logic        dst_rdy_o;
    logic [35:0] data_o;
    logic        src0_rdy_o, src1_rdy_o;
    logic        dst0_rdy_i = 1'b1;
    logic        dst1_rdy_i = 1'b1;
    logic [15:0] pkt0_cnt, pkt1_cnt, drop_cnt, err_cnt;
    logic        busy;

    always #5 clk = ~clk;

    ext_fifo_chan_demux dut (
        .clk        (clk),
        .rst        (rst),
        .data_i     (data_i),
        .src_rdy_i  (src_rdy_i),
        .dst_rdy_o  (dst_rdy_o),
        .data_o     (data_o),
        .src0_rdy_o (src0_rdy_o),
        .dst0_rdy_i (dst0_rdy_i),
        .src1_rdy_o (src1_rdy_o),
        .dst1_rdy_i (dst1_rdy_i),
        .pkt0_cnt   (pkt0_cnt),
        .pkt1_cnt   (pkt1_cnt),
        .drop_cnt   (drop_cnt),
        .err_cnt    (err_cnt),
        .busy       (busy)
    );

    typedef struct packed {
        logic        ch;
        logic [35:0] w;
    } ent_t;

    int tests = 0;
    int fails = 0;

    // Reference model: words awaiting delivery, packet context, counters.
    ent_t        q[$];
    logic [35:0] m_data;
    bit          m_inpkt;
    bit          m_ch;
    int          m_pkt0, m_pkt1, m_drop, m_err;
    bit          d0 = 1'b1, d1 = 1'b1;
    bit          last_acc;

    function automatic logic [35:0] mk(input bit sof, input bit eof, input bit ch,
                                       input logic [31:0] payload);
        logic [35:0] w;
        w       = {2'b11, eof, sof, payload};
        w[16]   = ch;
        return w;
    endfunction

    function automatic logic [15:0] sat(input int v);
        return (v > 65535) ? 16'hFFFF : 16'(v);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_data  = '0;
        m_inpkt = 1'b0;
        m_ch    = 1'b0;
        m_pkt0  = 0;
        m_pkt1  = 0;
        m_drop  = 0;
        m_err   = 0;
    endtask

    task automatic do_reset();
        src_rdy_i = 1'b0;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        $display("[TB] reset");
    endtask

    // One clock: drive, check all outputs against the model, advance model.
    task automatic step(input bit sr, input logic [35:0] w);
        bit   hv, hch, taken, acc;
        ent_t head;
        src_rdy_i  = sr;
        data_i     = w;
        dst0_rdy_i = d0;
        dst1_rdy_i = d1;
        #1;
        hv    = (q.size() > 0);
        head  = hv ? q[0] : '0;
        hch   = head.ch;
        taken = hv && (hch ? d1 : d0);
        acc   = sr && (!hv || taken);
        chk("src0_rdy", src0_rdy_o, hv && !hch);
        chk("src1_rdy", src1_rdy_o, hv && hch);
        chk("dst_rdy", dst_rdy_o, !hv || taken);
        chk("data_o", data_o, m_data);
        chk("busy", busy, m_inpkt || hv);
        chk("pkt0_cnt", pkt0_cnt, sat(m_pkt0));
        chk("pkt1_cnt", pkt1_cnt, sat(m_pkt1));
        chk("drop_cnt", drop_cnt, sat(m_drop));
        chk("err_cnt", err_cnt, sat(m_err));
        if (taken) begin
            void'(q.pop_front());
            if (head.w[33]) begin
                if (hch) m_pkt1++;
                else     m_pkt0++;
            end
        end
        if (acc) begin
            if (w[32]) begin
                if (m_inpkt) m_err++;
                m_ch    = w[16];
                m_inpkt = !w[33];
                q.push_back('{ch: w[16], w: w});
                m_data  = w;
            end else if (m_inpkt) begin
                q.push_back('{ch: m_ch, w: w});
                m_data  = w;
                if (w[33]) m_inpkt = 1'b0;
            end else begin
                m_drop++;
            end
        end
        last_acc = acc;
        if (sr || taken)
            $display("[TB] t=%0t sr=%0b w=%h acc=%0b taken=%0b d0=%0b d1=%0b",
                     $time, sr, w, acc, taken, d0, d1);
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [35:0] w);
        int n = 0;
        do begin
            step(1'b1, w);
            n++;
        end while (!last_acc && n < 64);
        chk("push_timeout", {63'd0, last_acc}, 64'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0);
    endtask

    initial begin
        model_clear();
        do_reset();
        chk("rst_data_o", data_o, 36'd0);
        chk("rst_dst_rdy", dst_rdy_o, 1'b1);
        idle(1);

        // Single-word packet to ch1.
        push(mk(1, 1, 1, 32'hA5A5_0001));
        idle(2);
        chk("single_pkt1", pkt1_cnt, 16'd1);
        chk("single_pkt0", pkt0_cnt, 16'd0);

        // Back-to-back: 3 words to ch0, then 2 words to ch1.
        push(mk(1, 0, 0, 32'h0000_1000));
        push(mk(0, 0, 0, 32'h0000_1001));
        push(mk(0, 1, 0, 32'h0000_1002));
        push(mk(1, 0, 1, 32'h0000_2000));
        push(mk(0, 1, 0, 32'h0000_2001));
        idle(2);
        chk("b2b_pkt0", pkt0_cnt, 16'd1);
        chk("b2b_pkt1", pkt1_cnt, 16'd2);

        // Backpressure on ch0 mid-packet, with ch1 traffic queued behind.
        push(mk(1, 0, 0, 32'h0000_3000));
        push(mk(0, 0, 0, 32'h0000_3001));
        d0 = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b1, mk(0, 0, 0, 32'h0000_3002));
        chk("bp_hold", data_o, mk(0, 0, 0, 32'h0000_3001));
        d0 = 1'b1;
        push(mk(0, 0, 0, 32'h0000_3002));
        push(mk(0, 1, 0, 32'h0000_3003));
        push(mk(1, 1, 1, 32'h0000_4000));
        idle(2);
        chk("bp_pkt0", pkt0_cnt, 16'd2);
        chk("bp_pkt1", pkt1_cnt, 16'd3);

        // Stray words outside a packet.
        push(mk(0, 0, 0, 32'h0000_5000));
        push(mk(0, 1, 0, 32'h0000_5001));
        idle(1);
        chk("stray_drop", drop_cnt, 16'd2);

        // Truncated packet: SOF ch0, data, then SOF+EOF ch1.
        push(mk(1, 0, 0, 32'h0000_6000));
        push(mk(0, 0, 0, 32'h0000_6001));
        push(mk(1, 1, 1, 32'h0000_6002));
        idle(2);
        chk("trunc_err", err_cnt, 16'd1);
        chk("trunc_pkt1", pkt1_cnt, 16'd4);
        chk("trunc_pkt0", pkt0_cnt, 16'd2);
        chk("trunc_idle", busy, 1'b0);

        // Reset after the second word of a 4-word packet.
        push(mk(1, 0, 0, 32'h0000_7000));
        push(mk(0, 0, 0, 32'h0000_7001));
        do_reset();
        chk("rst2_src0", src0_rdy_o, 1'b0);
        chk("rst2_data", data_o, 36'd0);
        push(mk(0, 0, 0, 32'h0000_7002));
        push(mk(0, 1, 0, 32'h0000_7003));
        push(mk(1, 1, 1, 32'h0000_7100));
        idle(2);
        chk("rst2_drop", drop_cnt, 16'd2);
        chk("rst2_pkt1", pkt1_cnt, 16'd1);

        // Randomized traffic and backpressure.
        for (int i = 0; i < 1500; i++) begin
            bit sr, sof, eof, ch;
            sr  = ($urandom_range(0, 3) != 0);
            sof = ($urandom_range(0, 3) == 0);
            eof = ($urandom_range(0, 3) == 0);
            ch  = $urandom_range(0, 1);
            d0  = ($urandom_range(0, 3) != 0);
            d1  = ($urandom_range(0, 3) != 0);
            step(sr, mk(sof, eof, ch, $urandom));
        end
        d0 = 1'b1;
        d1 = 1'b1;
        idle(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
